// File: rtl/pbit_sampler_array.sv
// Sequential Gibbs sampler: each enabled RUN cycle turns one p-bit's 4-bit activation into a spin
// by comparing it with a 4-bit LFSR draw, so that P(1) = act/16.
module pbit_sampler_array #(
   parameter int unsigned N    = 5,
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           start,
   input  logic [7:0]     sweeps,
   input  logic [4*N-1:0] act,
   input  logic [N-1:0]   clamp_mask,
   input  logic [N-1:0]   clamp_val,
   output logic [N-1:0]   state,
   output logic [3:0]     upd_idx,
   output logic           busy,
   output logic           done,
   output logic [7:0]     sweep_cnt
);

   // A zero seed would lock the LFSR at zero forever.
   localparam logic [15:0] LfsrInit = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [3:0]  LastIdx  = 4'(N - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

   fsm_e         r_fsm;
   fsm_e         w_fsm_next;
   logic [15:0]  r_lfsr;
   logic [15:0]  w_lfsr_next;
   logic [N-1:0] r_state;
   logic [N-1:0] w_state_next;
   logic [3:0]   r_idx;
   logic [7:0]   r_cnt;
   logic [7:0]   r_target;
   logic [7:0]   w_cnt_inc;
   logic [3:0]   w_act_sel;
   logic         w_mask_sel;
   logic         w_val_sel;
   logic         w_sample;
   logic         w_step;
   logic         w_last;
   logic         w_launch;

   assign w_step      = (r_fsm == StRun) && en;
   assign w_last      = (r_idx == LastIdx);
   assign w_cnt_inc   = r_cnt + 8'd1;
   assign w_launch    = (r_fsm == StIdle) && start && (sweeps != 8'd0);
   assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

   // Select the activation and clamp controls of the bit in its update slot.
   always_comb begin
      w_act_sel  = 4'd0;
      w_mask_sel = 1'b0;
      w_val_sel  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (r_idx == 4'(i)) begin
            w_act_sel  = act[4*i +: 4];
            w_mask_sel = clamp_mask[i];
            w_val_sel  = clamp_val[i];
         end
      end
   end

   assign w_sample = w_mask_sel ? w_val_sel : (w_act_sel > r_lfsr[3:0]);

   always_comb begin
      w_state_next = r_state;
      for (int i = 0; i < N; i++) begin
         if (r_idx == 4'(i)) begin
            w_state_next[i] = w_sample;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm <= StIdle;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   always_comb begin
      w_fsm_next = r_fsm;
      unique case (r_fsm)
         StIdle: begin
            if (start) begin
               w_fsm_next = (sweeps != 8'd0) ? StRun : StDone;
            end
         end
         StRun: begin
            if (w_step && w_last && (w_cnt_inc == r_target)) begin
               w_fsm_next = StDone;
            end
         end
         StDone:  w_fsm_next = StIdle;
         default: w_fsm_next = StIdle;
      endcase
   end

   always_comb begin
      busy = (r_fsm == StRun);
      done = (r_fsm == StDone);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= '0;
         r_idx    <= 4'd0;
         r_cnt    <= 8'd0;
         r_target <= 8'd0;
         r_lfsr   <= LfsrInit;
      end else if (w_launch) begin
         r_target <= sweeps;
         r_idx    <= 4'd0;
         r_cnt    <= 8'd0;
      end else if (w_step) begin
         r_state <= w_state_next;
         r_lfsr  <= w_lfsr_next;
         if (w_last) begin
            r_idx <= 4'd0;
            r_cnt <= w_cnt_inc;
         end else begin
            r_idx <= r_idx + 4'd1;
         end
      end
   end

   assign state     = r_state;
   assign upd_idx   = r_idx;
   assign sweep_cnt = r_cnt;

endmodule

// File: tb/tb_pbit_sampler_array.sv
// Bench for pbit_sampler_array: directed scenarios plus random traffic, with every cycle
// compared against a behavioural model of the sampler (two DUTs, default and zero seed).
`timescale 1ns/1ps
module tb_pbit_sampler_array;

   localparam int N = 5;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           en = 1'b0;
   logic           start = 1'b0;
   logic [7:0]     sweeps = 8'd0;
   logic [4*N-1:0] act = '0;
   logic [N-1:0]   clamp_mask = '0;
   logic [N-1:0]   clamp_val = '0;

   logic [N-1:0]   state0, state1;
   logic [3:0]     idx0, idx1;
   logic           busy0, busy1, done0, done1;
   logic [7:0]     cnt0, cnt1;

   pbit_sampler_array #(.N(N), .SEED(16'hACE1)) u_dut0 (
      .clk(clk), .rst(rst), .en(en), .start(start), .sweeps(sweeps), .act(act),
      .clamp_mask(clamp_mask), .clamp_val(clamp_val), .state(state0), .upd_idx(idx0),
      .busy(busy0), .done(done0), .sweep_cnt(cnt0)
   );

   pbit_sampler_array #(.N(N), .SEED(16'h0000)) u_dut1 (
      .clk(clk), .rst(rst), .en(en), .start(start), .sweeps(sweeps), .act(act),
      .clamp_mask(clamp_mask), .clamp_val(clamp_val), .state(state1), .upd_idx(idx1),
      .busy(busy1), .done(done1), .sweep_cnt(cnt1)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // Behavioural model: mode 0 idle, 1 running, 2 done.
   int          m_mode, m_idx, m_cnt, m_tgt, m_last;
   bit          m_upd;
   logic [N-1:0] m_st[2];
   logic [15:0]  m_lf[2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode = 0; m_idx = 0; m_cnt = 0; m_tgt = 0; m_upd = 0; m_last = 0;
         m_st[0] = '0; m_st[1] = '0;
         m_lf[0] = 16'hACE1; m_lf[1] = 16'h0001;
      end else begin
         m_upd = 0;
         if (m_mode == 0) begin
            if (start) begin
               if (sweeps != 0) begin
                  m_mode = 1; m_tgt = sweeps; m_idx = 0; m_cnt = 0;
               end else begin
                  m_mode = 2;
               end
            end
         end else if (m_mode == 1) begin
            if (en) begin
               for (int k = 0; k < 2; k++) begin
                  int a, r;
                  a = (act >> (4 * m_idx)) & 15;
                  r = m_lf[k] % 16;
                  m_st[k][m_idx] = clamp_mask[m_idx] ? clamp_val[m_idx] : (a > r);
                  m_lf[k] = (m_lf[k] % 2) ? ((m_lf[k] / 2) ^ 16'hB400) : (m_lf[k] / 2);
               end
               m_upd = 1; m_last = m_idx;
               m_idx = m_idx + 1;
               if (m_idx == N) begin
                  m_idx = 0;
                  m_cnt = m_cnt + 1;
                  if (m_cnt == m_tgt) m_mode = 2;
               end
            end
         end else begin
            m_mode = 0;
         end
      end
   end

   bit chk_on = 0;
   bit cnt_on = 0;
   int ones0 = 0;
   int ones1 = 0;

   always @(negedge clk) begin
      if (chk_on) begin
         check("state0", state0, m_st[0]);
         check("state1", state1, m_st[1]);
         check("upd_idx", idx0, m_idx);
         check("upd_idx_s0", idx1, m_idx);
         check("busy", busy0, m_mode == 1);
         check("busy_s0", busy1, m_mode == 1);
         check("done", done0, m_mode == 2);
         check("done_s0", done1, m_mode == 2);
         check("sweep_cnt", cnt0, m_cnt);
         check("sweep_cnt_s0", cnt1, m_cnt);
         if (cnt_on && m_upd) begin
            ones0 += state0[m_last];
            ones1 += state1[m_last];
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Launch from IDLE and count cycles until done is seen; -1 on timeout.
   task automatic run(input int sw, input int limit, output int cyc);
      sweeps = 8'(sw);
      start  = 1'b1;
      tick();
      start  = 1'b0;
      cyc    = 0;
      if (done0) return;
      cyc = -1;
      for (int c = 1; c <= limit; c++) begin
         tick();
         if (done0) begin
            cyc = c;
            break;
         end
      end
      if (cyc < 0) check("run_timeout", 0, 1);
   endtask

   int cyc;

   initial begin
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk_on = 1;
      en = 1'b1;

      // Mid-run reset
      act = {N{4'd9}};
      sweeps = 8'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      #1;
      check("t1_state", state0, 0);
      check("t1_idx", idx0, 0);
      check("t1_busy", busy0, 0);
      check("t1_done", done0, 0);
      check("t1_cnt", cnt0, 0);
      tick();
      rst = 1'b0;
      tick();

      // All-zero activations, three sweeps
      act = '0;
      run(3, 100, cyc);
      check("t2_latency", cyc, 15);
      check("t2_cnt", cnt0, 3);
      check("t2_state", state0, 0);
      tick();

      // Clamped bits
      clamp_mask = 5'b00101;
      clamp_val  = 5'b00101;
      run(1, 50, cyc);
      check("t3_latency", cyc, 5);
      check("t3_state", state0, 5'b00101);
      tick();
      clamp_mask = '0;
      clamp_val  = '0;

      // Zero sweeps
      run(0, 5, cyc);
      check("t5_latency", cyc, 0);
      check("t5_busy", busy0, 0);
      check("t5_state", state0, 5'b00101);
      tick();
      check("t5_done_one_cycle", done0, 0);

      // Enable toggling every cycle
      act = 20'($urandom);
      sweeps = 8'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      en = 1'b0;
      cyc = -1;
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (done0) begin
            cyc = c;
            break;
         end
         en = ~en;
      end
      check("t4_latency", cyc, 20);
      en = 1'b1;
      tick();

      // Statistics at act=8
      act = {N{4'd8}};
      ones0 = 0;
      ones1 = 0;
      cnt_on = 1;
      run(255, 2000, cyc);
      cnt_on = 0;
      check("t6_latency", cyc, 1275);
      check("t6_cnt", cnt0, 255);
      check("t6_ones_seed", (ones0 >= 567 && ones0 <= 707), 1);
      check("t6_ones_seed0", (ones1 >= 567 && ones1 <= 707), 1);
      tick();

      // Random traffic, including starts while busy and a mid-run reset
      for (int c = 0; c < 1200; c++) begin
         act        = 20'($urandom);
         clamp_mask = 5'($urandom);
         clamp_val  = 5'($urandom);
         en         = ($urandom_range(0, 3) != 0);
         start      = ($urandom_range(0, 7) == 0);
         sweeps     = 8'($urandom_range(0, 3));
         rst        = (c == 600);
         tick();
      end
      rst = 1'b0;
      start = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
